// File: rtl/demux_1_4_reg.sv
// Registered 1-to-4 demultiplexer.
// x is steered to y[{s1,s0}] and every other output is cleared. vld carries a
// one-hot copy of the select, so a routed zero can be told apart from an
// unselected channel. Each output channel is its own small register lane.

// One output channel: loads x when hit, loads zero otherwise, and holds when en=0.
module demux_1_4_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hit,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             v
);

  // Channel register: clears asynchronously, updates only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
      v <= 1'b0;
    end else if (en) begin
      y <= hit ? x : '0;
      v <= hit;
    end
  end

endmodule

module demux_1_4_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       vld
);

  localparam int NUM_LANES = 4;

  logic [1:0]                       sel;
  logic [NUM_LANES-1:0]             hit;
  logic [NUM_LANES-1:0][WIDTH-1:0]  y_lane;
  logic [NUM_LANES-1:0]             v_lane;

  assign sel = {s1, s0};

  // Exactly one lane sees hit, so at most one output can ever be nonzero.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign hit[k] = (sel == 2'(k));

    demux_1_4_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .hit   (hit[k]),
      .x     (x),
      .y     (y_lane[k]),
      .v     (v_lane[k])
    );
  end

  assign y0  = y_lane[0];
  assign y1  = y_lane[1];
  assign y2  = y_lane[2];
  assign y3  = y_lane[3];
  assign vld = v_lane;

endmodule

// File: tb/tb_demux_1_4_reg.sv
// Scoreboard bench for demux_1_4_reg: a WIDTH=8 and a WIDTH=1 instance share
// stimulus; the reference model keeps an array of four channel values.
module tb_demux_1_4_reg;

  logic       clk = 1'b0;
  logic       rst_n, en, s0, s1;
  logic [7:0] x;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] vld;
  logic       a0, a1, a2, a3;
  logic [3:0] vld1;

  typedef struct packed {
    logic [3:0][7:0] y;
    logic [3:0]      v;
  } exp_t;

  exp_t            sb[$];
  logic [3:0][7:0] ref_y;
  logic [3:0]      ref_v;
  int              n_tests = 0;
  int              n_fail  = 0;

  demux_1_4_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1), .x(x),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .vld(vld)
  );

  demux_1_4_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1), .x(x[0]),
    .y0(a0), .y1(a1), .y2(a2), .y3(a3), .vld(vld1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and push the response the spec predicts for it.
  task automatic drive(input logic r, input logic e, input logic b0, input logic b1,
                       input logic [7:0] d);
    int   sel;
    exp_t t;
    @(negedge clk);
    rst_n = r; en = e; s0 = b0; s1 = b1; x = d;
    sel = int'({b1, b0});
    if (!r) begin
      ref_y = '0;
      ref_v = '0;
    end else if (e) begin
      for (int k = 0; k < 4; k++) ref_y[k] = (k == sel) ? d : 8'h00;
      ref_v = 4'(1 << sel);
    end
    t.y = ref_y;
    t.v = ref_v;
    sb.push_back(t);
    @(posedge clk);
  endtask

  // Monitor: after every edge, compare both instances with the oldest expectation.
  initial begin : monitor
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check("y_w8",   {y3, y2, y1, y0}, t.y);
        check("vld_w8", vld, t.v);
        check("y_w1",   {a3, a2, a1, a0}, {t.y[3][0], t.y[2][0], t.y[1][0], t.y[0][0]});
        check("vld_w1", vld1, t.v);
      end
    end
  end

  initial begin : stim
    int guard;
    rst_n = 1'b0; en = 1'b0; s0 = 1'b0; s1 = 1'b0; x = 8'h00;
    ref_y = '0; ref_v = '0;
    #1;
    check("reset_y",   {y3, y2, y1, y0}, 32'h0);
    check("reset_vld", vld, 4'b0000);

    // Full sweep in (x, s0 s1) order: 00, 01, 10, 11 for x=0 then x=1.
    for (int xv = 0; xv < 2; xv++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(xv));
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'(xv));
      drive(1'b1, 1'b1, 1'b1, 1'b0, 8'(xv));
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'(xv));
    end

    // Enable hold: load y2, then toggle everything with en low.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));

    // Wide pattern rotating through all four channels.
    for (int k = 0; k < 4; k++)
      drive(1'b1, 1'b1, 1'(k), 1'(k >> 1), 8'hA5);

    // Back-to-back switch 00 -> 11.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h01);

    // Asynchronous reset mid-stream with y1 loaded.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_y",   {y3, y2, y1, y0}, 32'h0);
    check("async_rst_vld", vld, 4'b0000);
    check("async_rst_w1",  {vld1, a3, a2, a1, a0}, 8'h00);
    ref_y = '0;
    ref_v = '0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), 8'($urandom));

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
